// File: rtl/nano_ctrl_seq_if.sv
// Memory-side bus of the nanoprocessor sequencer: RAM data/ready handshake
// plus the read/write requests and the address-mux select.
interface nano_ctrl_seq_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              mem_re;
  logic              mem_we;
  logic              addr_sel;

  modport master (
    input  mem_data,
    input  mem_ready,
    output mem_re,
    output mem_we,
    output addr_sel
  );

  modport slave (
    output mem_data,
    output mem_ready,
    input  mem_re,
    input  mem_we,
    input  addr_sel
  );
endinterface

// File: rtl/nano_ctrl_seq.sv
// Fetch-fetch-execute instruction sequencer for the 8-bit nanoprocessor, with an
// optional mem_ready watchdog that parks the core in HALT with a sticky bus_error.
module nano_ctrl_seq #(
  parameter int DATA_W       = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  nano_ctrl_seq_if.master   mem,
  input  logic              z_flag,
  input  logic              c_flag,
  output logic              inc_PC,
  output logic              load_PC,
  output logic              load_ADDR,
  output logic              load_ACC,
  output logic              load_FLAGS,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] opcode,
  output logic              halted,
  output logic              bus_error,
  output logic              illegal_op
);

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_ADDR = 2'd1,
    EXEC       = 2'd2,
    HALT       = 2'd3
  } state_e;

  localparam int               CNT_W     = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(WAIT_TIMEOUT);

  localparam logic [DATA_W-1:0] OP_NOP   = DATA_W'(8'h00);
  localparam logic [DATA_W-1:0] OP_LOAD  = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_STORE = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] OP_ADD   = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] OP_SUB   = DATA_W'(8'h04);
  localparam logic [DATA_W-1:0] OP_AND   = DATA_W'(8'h05);
  localparam logic [DATA_W-1:0] OP_OR    = DATA_W'(8'h06);
  localparam logic [DATA_W-1:0] OP_XOR   = DATA_W'(8'h07);
  localparam logic [DATA_W-1:0] OP_JMP   = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] OP_JZ    = DATA_W'(8'h09);
  localparam logic [DATA_W-1:0] OP_JC    = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] OP_HALT  = DATA_W'(8'h0F);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              bus_error_q, bus_error_d;

  logic addr_sel_c;
  logic mem_re_c;
  logic mem_we_c;
  logic mem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH_OP;
      opcode_q    <= '0;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    wait_cnt_d  = '0;
    bus_error_d = bus_error_q;
    inc_PC      = 1'b0;
    load_PC     = 1'b0;
    load_ADDR   = 1'b0;
    load_ACC    = 1'b0;
    load_FLAGS  = 1'b0;
    alu_op      = 3'd0;
    illegal_op  = 1'b0;
    addr_sel_c  = 1'b0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_wait    = 1'b0;

    case (state_q)
      FETCH_OP: begin
        mem_re_c = 1'b1;
        mem_wait = 1'b1;
        if (mem.mem_ready) begin
          opcode_d = mem.mem_data;
          inc_PC   = 1'b1;
          state_d  = FETCH_ADDR;
        end
      end
      FETCH_ADDR: begin
        mem_re_c = 1'b1;
        mem_wait = 1'b1;
        if (mem.mem_ready) begin
          load_ADDR = 1'b1;
          inc_PC    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        case (opcode_q)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            addr_sel_c = 1'b1;
            mem_re_c   = 1'b1;
            mem_wait   = 1'b1;
            case (opcode_q)
              OP_ADD:  alu_op = 3'd1;
              OP_SUB:  alu_op = 3'd2;
              OP_AND:  alu_op = 3'd3;
              OP_OR:   alu_op = 3'd4;
              OP_XOR:  alu_op = 3'd5;
              default: alu_op = 3'd0;
            endcase
            if (mem.mem_ready) begin
              load_ACC   = 1'b1;
              load_FLAGS = 1'b1;
              state_d    = FETCH_OP;
            end
          end
          OP_STORE: begin
            addr_sel_c = 1'b1;
            mem_we_c   = 1'b1;
            mem_wait   = 1'b1;
            if (mem.mem_ready) begin
              state_d = FETCH_OP;
            end
          end
          OP_JMP: begin
            load_PC = 1'b1;
            state_d = FETCH_OP;
          end
          OP_JZ: begin
            load_PC = z_flag;
            state_d = FETCH_OP;
          end
          OP_JC: begin
            load_PC = c_flag;
            state_d = FETCH_OP;
          end
          OP_NOP: begin
            state_d = FETCH_OP;
          end
          OP_HALT: begin
            state_d = HALT;
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH_OP;
          end
        endcase
      end
      default: begin
      end
    endcase

    // The request stays up in the expiry cycle; only the state change and error flag differ.
    if ((WAIT_TIMEOUT > 0) && mem_wait && !mem.mem_ready) begin
      if (wait_cnt_q == TIMEOUT_C) begin
        bus_error_d = 1'b1;
        state_d     = HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end

    if (reset) begin
      inc_PC     = 1'b0;
      load_PC    = 1'b0;
      load_ADDR  = 1'b0;
      load_ACC   = 1'b0;
      load_FLAGS = 1'b0;
      alu_op     = 3'd0;
      illegal_op = 1'b0;
      addr_sel_c = 1'b0;
      mem_re_c   = 1'b0;
      mem_we_c   = 1'b0;
    end
  end

  assign mem.addr_sel = addr_sel_c;
  assign mem.mem_re   = mem_re_c;
  assign mem.mem_we   = mem_we_c;
  assign opcode       = reset ? '0 : opcode_q;
  assign halted       = !reset && (state_q == HALT);
  assign bus_error    = !reset && bus_error_q;

endmodule

// File: tb/tb_nano_ctrl_seq.sv
// Self-checking bench for nano_ctrl_seq: directed instruction table, hand-written
// halt/timeout/reset sequences and a randomized program against an instruction-level model.
module tb_nano_ctrl_seq;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic       inc_pc;
    logic       load_pc;
    logic       load_addr;
    logic       addr_sel;
    logic       mem_re;
    logic       mem_we;
    logic       load_acc;
    logic       load_flags;
    logic [2:0] alu_op;
    logic [7:0] opcode;
    logic       halted;
    logic       bus_error;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [7:0] op;
    int         w_op;
    int         w_addr;
    int         w_exec;
    logic       z;
    logic       c;
    int         exp_cyc;
    int         exp_inc;
    int         exp_lpc;
    int         exp_acc;
    int         exp_ill;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       z_flag;
  logic       c_flag;
  logic       inc_PC, load_PC, load_ADDR, load_ACC, load_FLAGS;
  logic [2:0] alu_op;
  logic [7:0] opcode;
  logic       halted, bus_error, illegal_op;

  int checks = 0;
  int errors = 0;

  int cyc_cnt, inc_cnt, lpc_cnt, acc_cnt, ill_cnt;

  logic [7:0] m_opcode;
  logic       m_bus_err;
  logic       m_halted;

  nano_ctrl_seq_if #(.DATA_W(8)) bus ();

  nano_ctrl_seq #(
    .DATA_W      (8),
    .WAIT_TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (bus.master),
    .z_flag    (z_flag),
    .c_flag    (c_flag),
    .inc_PC    (inc_PC),
    .load_PC   (load_PC),
    .load_ADDR (load_ADDR),
    .load_ACC  (load_ACC),
    .load_FLAGS(load_FLAGS),
    .alu_op    (alu_op),
    .opcode    (opcode),
    .halted    (halted),
    .bus_error (bus_error),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sampleOuts();
    outs_t s;
    s.inc_pc     = inc_PC;
    s.load_pc    = load_PC;
    s.load_addr  = load_ADDR;
    s.addr_sel   = bus.addr_sel;
    s.mem_re     = bus.mem_re;
    s.mem_we     = bus.mem_we;
    s.load_acc   = load_ACC;
    s.load_flags = load_FLAGS;
    s.alu_op     = alu_op;
    s.opcode     = opcode;
    s.halted     = halted;
    s.bus_error  = bus_error;
    s.illegal_op = illegal_op;
    return s;
  endfunction

  task automatic applyStimulus(input logic rdy, input logic [7:0] data, input logic z, input logic c);
    bus.mem_ready = rdy;
    bus.mem_data  = data;
    z_flag        = z;
    c_flag        = c;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sampleOuts();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %h expected %h (inc,lpc,laddr,asel,re,we,lacc,lflg,alu,opc,halt,berr,ill)",
               name, $time, act, exp);
    end
    cyc_cnt++;
    inc_cnt += int'(act.inc_pc);
    lpc_cnt += int'(act.load_pc);
    acc_cnt += int'(act.load_acc);
    ill_cnt += int'(act.illegal_op);
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, advance to the next falling edge.
  task automatic doCycle(input string name, input logic rdy, input logic [7:0] data,
                         input logic z, input logic c, input outs_t exp);
    applyStimulus(rdy, data, z, c);
    #1;
    checkOutput(name, exp);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++)
      doCycle("reset_outputs", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), '0);
    reset     = 1'b0;
    m_opcode  = 8'h00;
    m_bus_err = 1'b0;
    m_halted  = 1'b0;
  endtask

  task automatic checkHalted(input int n);
    outs_t exp;
    for (int i = 0; i < n; i++) begin
      exp           = '0;
      exp.halted    = 1'b1;
      exp.opcode    = m_opcode;
      exp.bus_error = m_bus_err;
      doCycle("halted", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), exp);
    end
  endtask

  // A memory access: 'waits' not-ready cycles then a ready cycle; TIMEOUT waits are
  // tolerated and the next not-ready cycle ends in a halted bus error.
  task automatic memPhase(input string name, input int waits, input outs_t base, input outs_t fin,
                          input logic [7:0] data, output bit done);
    outs_t exp;
    logic  rdy;
    done = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      rdy           = (i == waits);
      exp           = rdy ? outs_t'(base | fin) : base;
      exp.opcode    = m_opcode;
      exp.bus_error = m_bus_err;
      doCycle(name, rdy, rdy ? data : 8'($urandom), 1'($urandom), 1'($urandom), exp);
      if (rdy) begin
        done = 1'b1;
      end else if (i == TIMEOUT) begin
        m_bus_err = 1'b1;
        m_halted  = 1'b1;
        return;
      end
    end
  endtask

  task automatic runInstr(input logic [7:0] op, input int w_op, input int w_addr, input int w_exec,
                          input logic z, input logic c);
    outs_t base, fin, exp;
    bit    ok;
    bit    legal;
    cyc_cnt = 0; inc_cnt = 0; lpc_cnt = 0; acc_cnt = 0; ill_cnt = 0;

    base = '0; base.mem_re = 1'b1;
    fin  = '0; fin.inc_pc  = 1'b1;
    memPhase("fetch_op", w_op, base, fin, op, ok);
    if (!ok) return;
    m_opcode = op;

    fin.load_addr = 1'b1;
    memPhase("fetch_addr", w_addr, base, fin, 8'($urandom), ok);
    if (!ok) return;

    legal = (op inside {[8'h00:8'h0A], 8'h0F});
    if (op inside {8'h01, [8'h03:8'h07]}) begin
      base          = '0;
      base.addr_sel = 1'b1;
      base.mem_re   = 1'b1;
      base.alu_op   = (op == 8'h01) ? 3'd0 : 3'(op - 8'h02);
      fin           = '0;
      fin.load_acc  = 1'b1;
      fin.load_flags = 1'b1;
      memPhase("exec_alu", w_exec, base, fin, 8'($urandom), ok);
    end else if (op == 8'h02) begin
      base          = '0;
      base.addr_sel = 1'b1;
      base.mem_we   = 1'b1;
      memPhase("exec_store", w_exec, base, '0, 8'($urandom), ok);
    end else begin
      exp            = '0;
      exp.opcode     = m_opcode;
      exp.bus_error  = m_bus_err;
      exp.load_pc    = (op == 8'h08) || (op == 8'h09 && z) || (op == 8'h0A && c);
      exp.illegal_op = !legal;
      doCycle("exec_ctl", 1'($urandom), 8'($urandom), z, c, exp);
      if (op == 8'h0F) m_halted = 1'b1;
    end
  endtask

  function automatic int randWait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 7;
    if (r == 1) return TIMEOUT;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [7:0] randOp();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 11) return 8'(r);
    if (r == 11) return 8'h0F;
    return 8'($urandom);
  endfunction

  vec_t  vecs [16];
  outs_t exp_c;

  initial begin
    vecs[0]  = '{8'h01, 0, 0, 0, 1'b0, 1'b0,  3, 2, 0, 1, 0};
    vecs[1]  = '{8'h03, 3, 3, 3, 1'b0, 1'b0, 12, 2, 0, 1, 0};
    vecs[2]  = '{8'h09, 0, 0, 0, 1'b1, 1'b0,  3, 2, 1, 0, 0};
    vecs[3]  = '{8'h09, 0, 0, 0, 1'b0, 1'b1,  3, 2, 0, 0, 0};
    vecs[4]  = '{8'h02, 1, 0, 2, 1'b0, 1'b0,  6, 2, 0, 0, 0};
    vecs[5]  = '{8'h3C, 0, 0, 0, 1'b1, 1'b1,  3, 2, 0, 0, 1};
    vecs[6]  = '{8'h0A, 2, 1, 0, 1'b0, 1'b1,  6, 2, 1, 0, 0};
    vecs[7]  = '{8'h0A, 0, 0, 0, 1'b1, 1'b0,  3, 2, 0, 0, 0};
    vecs[8]  = '{8'h07, 0, 4, 1, 1'b0, 1'b0,  8, 2, 0, 1, 0};
    vecs[9]  = '{8'h08, 0, 0, 0, 1'b0, 1'b0,  3, 2, 1, 0, 0};
    vecs[10] = '{8'h00, 1, 1, 0, 1'b1, 1'b1,  5, 2, 0, 0, 0};
    vecs[11] = '{8'h04, 1, 1, 1, 1'b0, 1'b0,  6, 2, 0, 1, 0};
    vecs[12] = '{8'h10, 0, 0, 0, 1'b0, 1'b0,  3, 2, 0, 0, 1};
    vecs[13] = '{8'h0B, 0, 0, 0, 1'b0, 1'b0,  3, 2, 0, 0, 1};
    vecs[14] = '{8'h05, 4, 0, 4, 1'b0, 1'b0, 11, 2, 0, 1, 0};
    vecs[15] = '{8'h06, 0, 0, 2, 1'b0, 1'b0,  5, 2, 0, 1, 0};

    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    m_opcode = 8'h00; m_bus_err = 1'b0; m_halted = 1'b0;
    @(negedge clk);
    doReset();

    for (int i = 0; i < 16; i++) begin
      runInstr(vecs[i].op, vecs[i].w_op, vecs[i].w_addr, vecs[i].w_exec, vecs[i].z, vecs[i].c);
      checkCount($sformatf("vec%0d_cycles", i), cyc_cnt, vecs[i].exp_cyc);
      checkCount($sformatf("vec%0d_inc_pc", i), inc_cnt, vecs[i].exp_inc);
      checkCount($sformatf("vec%0d_load_pc", i), lpc_cnt, vecs[i].exp_lpc);
      checkCount($sformatf("vec%0d_load_acc", i), acc_cnt, vecs[i].exp_acc);
      checkCount($sformatf("vec%0d_illegal", i), ill_cnt, vecs[i].exp_ill);
    end

    $display("[TB] halt instruction");
    runInstr(8'h0F, 0, 0, 0, 1'b0, 1'b0);
    checkCount("halt_cycles", cyc_cnt, 3);
    checkHalted(20);
    doReset();

    $display("[TB] watchdog expiry in address fetch");
    runInstr(8'h01, 0, 100, 0, 1'b0, 1'b0);
    checkCount("timeout_cycles", cyc_cnt, 1 + TIMEOUT + 1);
    checkCount("timeout_inc_pc", inc_cnt, 1);
    checkHalted(5);
    doReset();
    runInstr(8'h00, 0, 0, 0, 1'b0, 1'b0);
    checkCount("after_timeout_cycles", cyc_cnt, 3);

    $display("[TB] reset during address wait");
    runInstr(8'h03, 0, 0, 0, 1'b0, 1'b0);
    exp_c        = '0;
    exp_c.mem_re = 1'b1;
    exp_c.inc_pc = 1'b1;
    exp_c.opcode = m_opcode;
    doCycle("midrst_fetch_op", 1'b1, 8'h05, 1'b0, 1'b0, exp_c);
    m_opcode     = 8'h05;
    exp_c        = '0;
    exp_c.mem_re = 1'b1;
    exp_c.opcode = m_opcode;
    doCycle("midrst_wait0", 1'b0, 8'h77, 1'b0, 1'b0, exp_c);
    doCycle("midrst_wait1", 1'b0, 8'h77, 1'b0, 1'b0, exp_c);
    doReset();
    exp_c        = '0;
    exp_c.mem_re = 1'b1;
    doCycle("midrst_first_fetch", 1'b0, 8'h33, 1'b0, 1'b0, exp_c);
    runInstr(8'h00, 0, 0, 0, 1'b0, 1'b0);
    checkCount("midrst_recover_cycles", cyc_cnt, 3);

    $display("[TB] randomized program");
    for (int n = 0; n < 250; n++) begin
      runInstr(randOp(), randWait(), randWait(), randWait(), 1'($urandom), 1'($urandom));
      if (m_halted) begin
        checkHalted(int'($urandom_range(1, 4)));
        doReset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_limit: simulation did not complete");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/nano_ctrl_seq.md
Name: nano_ctrl_seq

Overview:
- Instruction sequencer for the 8-bit nanoprocessor.
- Drives the PC register (inc_PC/load_PC), the operand-address register, the accumulator/flags and the RAM strobes through a fetch–fetch–execute FSM.
- Holds the current opcode internally. Waits on a memory-ready handshake, and optionally times out to a halted bus-error state.

Parameters:
- DATA_W, 8, width of memory data and opcode.
- WAIT_TIMEOUT, 0, maximum cycles to wait for mem_ready in any memory state; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_data  in  DATA_W  RAM read data; sampled as opcode in FETCH_OP
- mem_ready  in  1  RAM access completes in the cycle it is high
- z_flag  in  1  accumulator-zero flag from datapath
- c_flag  in  1  carry flag from datapath
- inc_PC  out  1  PC <= PC+1 at next edge
- load_PC  out  1  PC <= operand-address register at next edge
- load_ADDR  out  1  operand-address register <= mem_data
- addr_sel  out  1  RAM address mux: 0 = PC, 1 = operand address
- mem_re  out  1  RAM read request
- mem_we  out  1  RAM write request (data = accumulator)
- load_ACC  out  1  accumulator <= ALU result
- load_FLAGS  out  1  Z/C <= ALU flags
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- opcode  out  DATA_W  current instruction register
- halted  out  1  high in HALT state
- bus_error  out  1  sticky; set on watchdog expiry
- illegal_op  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Instruction format: two bytes, opcode then operand address. All instructions are two bytes.
- Opcodes:
  - 0x00 NOP, 0x01 LOAD, 0x02 STORE, 0x03 ADD, 0x04 SUB, 0x05 AND, 0x06 OR, 0x07 XOR.
  - 0x08 JMP, 0x09 JZ, 0x0A JC, 0x0F HALT.
  - Any other value is illegal and executes as NOP.
- States: FETCH_OP, FETCH_ADDR, EXEC, HALT. The watchdog counter is separate.
- FETCH_OP:
  - addr_sel=0, mem_re=1.
  - When mem_ready=1: opcode <= mem_data, inc_PC=1, next state FETCH_ADDR.
  - Otherwise hold with no strobes.
- FETCH_ADDR:
  - addr_sel=0, mem_re=1.
  - When mem_ready=1: load_ADDR=1, inc_PC=1, next state EXEC.
- EXEC for LOAD and ALU ops:
  - addr_sel=1, mem_re=1, alu_op per opcode (LOAD = PASS).
  - When mem_ready=1: load_ACC=1, load_FLAGS=1, next state FETCH_OP.
- EXEC for STORE:
  - addr_sel=1, mem_we=1 until mem_ready=1, then next state FETCH_OP.
  - mem_re stays 0.
- EXEC for JMP: load_PC=1 for one cycle, next state FETCH_OP. Does not depend on mem_ready.
- EXEC for JZ/JC: load_PC = z_flag / c_flag, sampled in the EXEC cycle; next state FETCH_OP.
- EXEC for NOP: no strobe, next state FETCH_OP.
- EXEC for illegal opcode: no strobe, illegal_op=1 for that cycle, next state FETCH_OP.
- EXEC for HALT: next state HALT.
- HALT: all strobes 0, halted=1. Left only by reset.
- Strobe timing and invariants:
  - All strobes are combinational from state, opcode, mem_ready and flags.
  - Each strobe is high for exactly one cycle per completed access.
  - inc_PC and load_PC are never high in the same cycle.
  - mem_re and mem_we are never high together.
- Watchdog (WAIT_TIMEOUT > 0):
  - Counter clears on entry to any memory-waiting state and on each mem_ready.
  - Counter increments every cycle a memory state waits with mem_ready=0.
  - When it reaches WAIT_TIMEOUT: no strobe, bus_error <= 1, next state HALT.
  - Exactly WAIT_TIMEOUT cycles of waiting are tolerated; the expiry cycle is the (WAIT_TIMEOUT+1)th.
- Reset:
  - When reset=1 at a clock edge: state <= FETCH_OP, opcode <= 0, counter <= 0, bus_error <= 0.
  - While reset is high, all outputs are forced to 0.
  - Reset mid-access abandons the access with no strobe. The first fetch is issued in the cycle after reset deasserts.
- Width rules:
  - The opcode is compared on the full DATA_W bits.
  - alu_op is 0 for any non-ALU opcode.

Test Plan:
- Reset, mem_ready tied 1, program 0x01 0x10 (LOAD) → inc_PC pulses in cycles 1 and 2, load_ADDR in cycle 2, addr_sel=1 with load_ACC/load_FLAGS/alu_op=0 in cycle 3, FETCH_OP in cycle 4.
- ADD with mem_ready delayed 3 cycles in every state → each strobe fires only in the mem_ready cycle; total 12 cycles; inc_PC count = 2.
- JZ with z_flag=1 → load_PC=1 and inc_PC=0 in EXEC. Repeat with z_flag=0 → no load_PC; PC advanced exactly 2.
- STORE 0x02 0x20 → mem_we=1, addr_sel=1, mem_re=0 until mem_ready, then FETCH_OP.
- Opcode 0x3C → illegal_op pulse for 1 cycle, then next fetch. Opcode 0x0F → halted=1 stays high for 20 cycles with no strobes, until reset.
- WAIT_TIMEOUT=4, mem_ready held 0 in FETCH_ADDR → bus_error=1 and halted on the 5th wait cycle. Assert reset mid-wait in a second run → FETCH_OP with all outputs 0 during reset, bus_error=0.
